ram_serial_writer: RTL and testbench
====================================

Name: ram_serial_writer

Overview:
- Write side of the VGA frame buffer; the pixel-fetch reader sits on the other RAM port.
- Takes bytes from the UART receiver (one-cycle `rx_ready` strobe per byte) and packs RAM_WIDTH/8 bytes into one word.
- Writes each word to the frame RAM at sequential addresses; wraps to 0 after the last word of a 480x360x24 frame.
- Discards stale partial words on an inter-byte timeout and supports a host-driven frame restart.

Parameters:
- RAM_WIDTH, 32, RAM word width in bits; multiple of 8, >=16.
- RAM_DEPTH, (480*360*24)/RAM_WIDTH, number of words per frame (129600 at default).
- TIMEOUT_CYCLES, 100000, idle clk cycles after which a partial word is discarded.
- Derived: ADRESS_BITS = $clog2(RAM_DEPTH); BYTES_PER_WORD = RAM_WIDTH/8; MAX_ADRESS = RAM_DEPTH-1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_ready=1.
- rx_ready  in  1  one-cycle strobe, byte valid.
- restart  in  1  synchronous frame restart: clear packer and address.
- adress  out  ADRESS_BITS  RAM write address.
- data_in  out  RAM_WIDTH  RAM write data.
- we  out  1  RAM write enable, one-cycle pulse per word.
- frame_done  out  1  one-cycle pulse after the word at MAX_ADRESS is written.
- byte_count  out  $clog2(BYTES_PER_WORD)+1  bytes held in the current partial word.

Behaviour:
- Reset (rst=1 at posedge): adress=0, data_in=0, we=0, frame_done=0, byte_count=0, timeout counter=0, state=COLLECT.
- All outputs are registered.
- Byte packing:
  - An accepted byte (rx_ready=1) shifts in at the LSB: shift = {shift[RAM_WIDTH-9:0], rx_data}.
  - The first byte of a word ends up in the MSBs.
  - Bytes are accepted in every state; with RAM_WIDTH>=16 a word cannot complete in consecutive cycles.
- States:
  - COLLECT:
    - On rx_ready, byte_count increments.
    - If that byte is number BYTES_PER_WORD: byte_count->0, data_in<=completed word, next state WRITE.
  - WRITE (one cycle): we=1 with data_in and the current adress stable.
    - Exit edge when adress==MAX_ADRESS: adress->0, next state DONE.
    - Exit edge otherwise: adress->adress+1, next state COLLECT.
  - DONE (one cycle): frame_done=1, then COLLECT.
- Latency: we is asserted in the cycle after the clock edge that samples the last byte's rx_ready=1. The incremented adress is visible the cycle after we.
- we is high only in WRITE. frame_done is high only in DONE. They are never high together.
- Timeout:
  - The counter clears on every accepted byte and whenever byte_count==0.
  - It increments each cycle while byte_count!=0 and rx_ready=0.
  - When it reaches TIMEOUT_CYCLES-1: byte_count->0 and counter->0. Partial bytes are dropped; adress is unchanged; no write occurs.
- restart:
  - Priority below rst, above everything else.
  - Next cycle: byte_count=0, timeout counter=0, adress=0, we=0, frame_done=0, state=COLLECT.
  - A byte strobed in the same cycle as restart is discarded.
  - restart while in WRITE: the write already presented in that cycle stands; the address increment is cancelled (adress->0).
- Simultaneous rx_ready and timeout expiry in the same cycle: the byte is accepted, the counter clears, and no discard occurs.
- data_in holds the last written word until the next completed word (it does not return to 0).
- A mid-frame restart is the only way to resynchronise frame alignment. There is no other framing.

Test Plan:
- Reset then bytes 0x11, 0x22, 0x33, 0x44 (one every 10 cycles) -> one we pulse with adress=0, data_in=0x11223344, starting 1 cycle after the 0x44 strobe; then adress=1, byte_count=0.
- Stream 8 bytes 0xA0..0xA7 -> writes 0xA0A1A2A3 at adress 0 and 0xA4A5A6A7 at adress 1; exactly two we pulses.
- Force adress to 129599 (stream 518396 bytes, or use a small RAM_DEPTH=4 build), then 4 more bytes -> we at MAX_ADRESS, frame_done pulse on the next cycle, adress=0, no we during DONE.
- Send 0x01, 0x02, then idle TIMEOUT_CYCLES cycles (TIMEOUT_CYCLES=16 build), then 0xDE, 0xAD, 0xBE, 0xEF -> no write for the partial word; first write data_in=0xDEADBEEF at adress 0.
- Write 3 words (adress=3), send 2 bytes, assert restart together with a third byte's rx_ready -> adress=0, byte_count=0, no we; the next 4 bytes are written at adress 0.
- Assert rst during WRITE (adress=5) -> next cycle we=0, adress=0, data_in=0, frame_done=0.

Source files
------------

// File: rtl/ram_serial_writer_if.sv
// Byte-in / RAM-write-out bundle between the UART receiver, the serial writer and the frame RAM port.
// Widths follow the same derivation as the writer, so both must be given matching parameters.
interface ram_serial_writer_if #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = (480 * 360 * 24) / RAM_WIDTH
);
    localparam int ADRESS_BITS = $clog2(RAM_DEPTH);
    localparam int BC_BITS     = $clog2(RAM_WIDTH / 8) + 1;

    logic [7:0]             rx_data;
    logic                   rx_ready;
    logic                   restart;
    logic [ADRESS_BITS-1:0] adress;
    logic [RAM_WIDTH-1:0]   data_in;
    logic                   we;
    logic                   frame_done;
    logic [BC_BITS-1:0]     byte_count;

    modport master (
        output rx_data, rx_ready, restart,
        input  adress, data_in, we, frame_done, byte_count
    );

    modport slave (
        input  rx_data, rx_ready, restart,
        output adress, data_in, we, frame_done, byte_count
    );
endinterface

// File: rtl/ram_serial_writer.sv
// Packs UART bytes (first byte in the MSBs) into RAM words and writes them at sequential
// frame-buffer addresses, with inter-byte timeout discard and host-driven frame restart.
module ram_serial_writer #(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_DEPTH      = (480 * 360 * 24) / RAM_WIDTH,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    ram_serial_writer_if.slave  bus
);
    localparam int ADRESS_BITS    = $clog2(RAM_DEPTH);
    localparam int BYTES_PER_WORD = RAM_WIDTH / 8;
    localparam int MAX_ADRESS     = RAM_DEPTH - 1;
    localparam int BC_BITS        = $clog2(BYTES_PER_WORD) + 1;
    localparam int TO_BITS        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [ADRESS_BITS-1:0] ADR_ZERO  = {ADRESS_BITS{1'b0}};
    localparam logic [ADRESS_BITS-1:0] ADR_ONE   = ADRESS_BITS'(1);
    localparam logic [ADRESS_BITS-1:0] ADR_MAX   = ADRESS_BITS'(MAX_ADRESS);
    localparam logic [BC_BITS-1:0]     BC_ZERO   = {BC_BITS{1'b0}};
    localparam logic [BC_BITS-1:0]     BC_ONE    = BC_BITS'(1);
    localparam logic [BC_BITS-1:0]     BC_LAST   = BC_BITS'(BYTES_PER_WORD - 1);
    localparam logic [TO_BITS-1:0]     TO_ZERO   = {TO_BITS{1'b0}};
    localparam logic [TO_BITS-1:0]     TO_ONE    = TO_BITS'(1);
    localparam logic [TO_BITS-1:0]     TO_LAST   = TO_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [RAM_WIDTH-1:0]   WORD_ZERO = {RAM_WIDTH{1'b0}};
    localparam logic [RAM_WIDTH-9:0]   SHIFT_ZERO = {(RAM_WIDTH-8){1'b0}};

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [ADRESS_BITS-1:0] adress_r, adress_s;
    logic [RAM_WIDTH-1:0]   data_r, data_s;
    logic                   we_r, we_s;
    logic                   frame_done_r, frame_done_s;
    logic [BC_BITS-1:0]     byte_count_r, byte_count_s;
    logic [TO_BITS-1:0]     timeout_r, timeout_s;
    // The top byte of a word is never shifted again, so only RAM_WIDTH-8 bits are kept.
    logic [RAM_WIDTH-9:0]   shift_r, shift_s;
    logic [RAM_WIDTH-1:0]   packed_s;

    assign packed_s = {shift_r, bus.rx_data};

    // Next-state and next-output decode; restart overrides sequencing and drops the strobed byte.
    always_comb begin
        state_s      = state_r;
        adress_s     = adress_r;
        data_s       = data_r;
        byte_count_s = byte_count_r;
        timeout_s    = timeout_r;
        shift_s      = shift_r;
        we_s         = 1'b0;
        frame_done_s = 1'b0;

        if (bus.restart) begin
            state_s      = COLLECT;
            adress_s     = ADR_ZERO;
            byte_count_s = BC_ZERO;
            timeout_s    = TO_ZERO;
        end else begin
            case (state_r)
                WRITE: begin
                    if (adress_r == ADR_MAX) begin
                        adress_s = ADR_ZERO;
                        state_s  = DONE;
                    end else begin
                        adress_s = adress_r + ADR_ONE;
                        state_s  = COLLECT;
                    end
                end
                DONE: begin
                    state_s = COLLECT;
                end
                default: begin
                    state_s = COLLECT;
                end
            endcase

            // A byte always wins over timeout expiry in the same cycle.
            if (bus.rx_ready) begin
                shift_s   = packed_s[RAM_WIDTH-9:0];
                timeout_s = TO_ZERO;
                if (byte_count_r == BC_LAST) begin
                    byte_count_s = BC_ZERO;
                    data_s       = packed_s;
                    state_s      = WRITE;
                end else begin
                    byte_count_s = byte_count_r + BC_ONE;
                end
            end else if (byte_count_r == BC_ZERO) begin
                timeout_s = TO_ZERO;
            end else if (timeout_r == TO_LAST) begin
                timeout_s    = TO_ZERO;
                byte_count_s = BC_ZERO;
            end else begin
                timeout_s = timeout_r + TO_ONE;
            end
        end

        we_s         = (state_s == WRITE);
        frame_done_s = (state_s == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= COLLECT;
            adress_r     <= ADR_ZERO;
            data_r       <= WORD_ZERO;
            we_r         <= 1'b0;
            frame_done_r <= 1'b0;
            byte_count_r <= BC_ZERO;
            timeout_r    <= TO_ZERO;
            shift_r      <= SHIFT_ZERO;
        end else begin
            state_r      <= state_s;
            adress_r     <= adress_s;
            data_r       <= data_s;
            we_r         <= we_s;
            frame_done_r <= frame_done_s;
            byte_count_r <= byte_count_s;
            timeout_r    <= timeout_s;
            shift_r      <= shift_s;
        end
    end

    assign bus.adress     = adress_r;
    assign bus.data_in    = data_r;
    assign bus.we         = we_r;
    assign bus.frame_done = frame_done_r;
    assign bus.byte_count = byte_count_r;
endmodule

// File: tb/tb_ram_serial_writer.sv
// Scoreboard bench for ram_serial_writer: a byte-level frame model predicts writes and frame_done
// pulses; an independent monitor compares them against what the DUT presents.
module tb_ram_serial_writer;
    localparam int RW    = 32;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;
    localparam int BPW   = RW / 8;

    typedef struct {
        int unsigned a;
        logic [31:0] d;
        int          c;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    wr_t         exp_q[$];
    int          fd_q[$];
    logic [7:0]  pend[$];
    int unsigned m_addr = 0;
    int          m_idle = 0;
    int          since_cmp = 99;

    ram_serial_writer_if #(.RAM_WIDTH(RW), .RAM_DEPTH(DEPTH)) bus ();

    ram_serial_writer #(
        .RAM_WIDTH(RW), .RAM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or flags frame end.
    always begin
        wr_t e;
        int  fc;
        @(posedge clk);
        #1;
        while (exp_q.size() != 0 && exp_q[0].c < cyc) begin
            e = exp_q.pop_front();
            total++; bad++;
            $display("FAIL we_missing act=none exp=adr %0d data %0h at cycle %0d", e.a, e.d, e.c);
        end
        while (fd_q.size() != 0 && fd_q[0] < cyc) begin
            fc = fd_q.pop_front();
            total++; bad++;
            $display("FAIL fd_missing act=none exp=pulse at cycle %0d", fc);
        end
        if (bus.we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL we_unexpected act=adr %0d data %0h exp=no write (cycle %0d)",
                         bus.adress, bus.data_in, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("wr_adress", 64'(bus.adress), 64'(e.a));
                chk("wr_data", 64'(bus.data_in), 64'(e.d));
                chk("wr_cycle", 64'(cyc), 64'(e.c));
            end
        end
        if (bus.frame_done === 1'b1) begin
            if (fd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL fd_unexpected act=pulse exp=none (cycle %0d)", cyc);
            end else begin
                fc = fd_q.pop_front();
                chk("fd_cycle", 64'(cyc), 64'(fc));
            end
        end
        if (bus.we === 1'b1 && bus.frame_done === 1'b1) begin
            total++; bad++;
            $display("FAIL we_and_fd act=both exp=exclusive (cycle %0d)", cyc);
        end
    end

    task automatic model_clear();
        pend.delete();
        m_addr    = 0;
        m_idle    = 0;
        since_cmp = 99;
    endtask

    // One clock of stimulus plus the reference model's view of that same sampling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic rs);
        logic [31:0] word;
        @(negedge clk);
        bus.rx_ready = v;
        bus.rx_data  = d;
        bus.restart  = rs;
        since_cmp++;
        if (rs) begin
            pend.delete();
            m_addr = 0;
            m_idle = 0;
        end else if (v) begin
            pend.push_back(d);
            m_idle = 0;
            if (pend.size() == BPW) begin
                word = 32'd0;
                foreach (pend[i]) word = (word << 8) | 32'(pend[i]);
                exp_q.push_back('{m_addr, word, cyc + 1});
                if (m_addr == DEPTH - 1) begin
                    fd_q.push_back(cyc + 2);
                    m_addr = 0;
                end else begin
                    m_addr = m_addr + 1;
                end
                pend.delete();
                since_cmp = 0;
            end
        end else if (pend.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                pend.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        step(1'b1, b, 1'b0);
        repeat (gap) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.restart  = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.restart  = 1'b0;

        do_reset();
        chk("rst_adress", 64'(bus.adress), 64'd0);
        chk("rst_data_in", 64'(bus.data_in), 64'd0);
        chk("rst_we", 64'(bus.we), 64'd0);
        chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
        chk("rst_byte_count", 64'(bus.byte_count), 64'd0);

        // Slow bytes, one every 10 cycles.
        send(8'h11, 9); send(8'h22, 9);
        chk("partial_byte_count", 64'(bus.byte_count), 64'd2);
        send(8'h33, 9); send(8'h44, 9);
        chk("t1_adress", 64'(bus.adress), 64'd1);
        chk("t1_byte_count", 64'(bus.byte_count), 64'd0);
        chk("t1_data_hold", 64'(bus.data_in), 64'h11223344);

        // Back-to-back stream of two words.
        do_reset();
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 0);
        idle(4);
        chk("t2_adress", 64'(bus.adress), 64'd2);

        // Whole frame to exercise the wrap and frame_done.
        do_reset();
        for (int w = 0; w < DEPTH; w++)
            for (int b = 0; b < BPW; b++) send(8'(w * 16 + b), 1);
        idle(3);
        chk("t3_wrap_adress", 64'(bus.adress), 64'd0);

        // Timeout discards the partial word.
        do_reset();
        send(8'h01, 0); send(8'h02, 0);
        idle(TMO + 2);
        chk("t4_timeout_byte_count", 64'(bus.byte_count), 64'd0);
        chk("t4_timeout_adress", 64'(bus.adress), 64'd0);
        send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 3);

        // Restart together with a byte strobe.
        do_reset();
        for (int i = 0; i < 3 * BPW; i++) send(8'(8'h30 + i), 2);
        chk("t5_pre_adress", 64'(bus.adress), 64'd3);
        send(8'h61, 1); send(8'h62, 1);
        step(1'b1, 8'h63, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("t5_restart_adress", 64'(bus.adress), 64'd0);
        chk("t5_restart_byte_count", 64'(bus.byte_count), 64'd0);
        send(8'h71, 0); send(8'h72, 0); send(8'h73, 0); send(8'h74, 3);

        // Reset while the word at adress 5 is being written.
        do_reset();
        for (int i = 0; i < 5 * BPW; i++) send(8'(8'h80 + i), 1);
        send(8'hC0, 1); send(8'hC1, 1); send(8'hC2, 1); send(8'hC3, 0);
        @(negedge clk);
        chk("t6_we_before_rst", 64'(bus.we), 64'd1);
        chk("t6_adress_before_rst", 64'(bus.adress), 64'd5);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        chk("t6_rst_we", 64'(bus.we), 64'd0);
        chk("t6_rst_adress", 64'(bus.adress), 64'd0);
        chk("t6_rst_data_in", 64'(bus.data_in), 64'd0);
        chk("t6_rst_frame_done", 64'(bus.frame_done), 64'd0);
        rst = 1'b0;

        // Randomised traffic: varied gaps, timeout-boundary idles, occasional restarts.
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                if (since_cmp >= 3) step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
                else idle(1);
            end else if (r < 8) begin
                idle(int'($urandom_range(TMO - 1, TMO + 1)));
            end else begin
                send(8'($urandom), int'($urandom_range(0, 3)));
            end
        end
        idle(6);
        chk("end_writes_drained", 64'(exp_q.size()), 64'd0);
        chk("end_fd_drained", 64'(fd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
